// File: rtl/opstack_pkg.sv
// opstack_pkg -- constants and types shared by the operand-stack controller.
//   DEF_DEPTH / DEF_WIDTH : default stack geometry
//   OP_*                  : supported JVM opcodes
//   state_e               : controller FSM states
//   err_e                 : fault codes reported on err_code
//   op_class_e, op_class  : opcode decode into execution classes
package opstack_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 32;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ICONST_M1 = 8'h02;
  localparam logic [7:0] OP_ICONST_5  = 8'h08;
  localparam logic [7:0] OP_POP       = 8'h57;
  localparam logic [7:0] OP_DUP       = 8'h59;
  localparam logic [7:0] OP_IADD      = 8'h60;
  localparam logic [7:0] OP_ISUB      = 8'h64;
  localparam logic [7:0] OP_IAND      = 8'h7E;
  localparam logic [7:0] OP_IOR       = 8'h80;
  localparam logic [7:0] OP_IXOR      = 8'h82;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_FETCH, S_ALU, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_UNDER   = 2'b01,
    ERR_OVER    = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    CL_NOP, CL_CONST, CL_DUP, CL_POP, CL_BIN, CL_ILL
  } op_class_e;

  function automatic op_class_e op_class(input logic [7:0] code);
    op_class_e r;
    if (code == OP_NOP) begin
      r = CL_NOP;
    end else if (code >= OP_ICONST_M1 && code <= OP_ICONST_5) begin
      r = CL_CONST;
    end else begin
      case (code)
        OP_POP:                                  r = CL_POP;
        OP_DUP:                                  r = CL_DUP;
        OP_IADD, OP_ISUB, OP_IAND, OP_IOR, OP_IXOR: r = CL_BIN;
        default:                                 r = CL_ILL;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/opstack_ram.sv
// opstack_ram -- storage for the stack entries below top-of-stack.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable, rdata updated on the rising edge (1-cycle latency)
//   raddr : read address
//   rdata : registered read data
// Contents are not reset.
module opstack_ram
  import opstack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/opstack_ctrl.sv
// opstack_ctrl -- JVM-style operand stack controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   op_valid   : op_code is valid
//   op_code    : JVM opcode, accepted when op_valid && op_ready
//   op_ready   : controller idle and able to accept an op
//   done       : one-cycle pulse when an op retires
//   tos        : top-of-stack value (0 when empty)
//   depth      : number of stack entries, 0..DEPTH
//   err        : sticky fault flag (controller halts until reset)
//   err_code   : 00 none, 01 underflow, 10 overflow, 11 illegal opcode
// TOS lives in a register; entry i below it lives at RAM address i.
module opstack_ctrl
  import opstack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  input  logic [7:0]             op_code,
  output logic                   op_ready,
  output logic                   done,
  output logic [WIDTH-1:0]       tos,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_e           state;
  err_e             err_q;
  err_e             acc_err;
  op_class_e        cls_in;
  op_class_e        cls;
  logic [7:0]       op;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] alu_res;
  logic signed [WIDTH-1:0] nxt_s;
  logic signed [WIDTH-1:0] tos_s;
  logic             accept;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;

  assign op_ready = (state == S_IDLE);
  assign accept   = op_valid && (state == S_IDLE);
  assign err_code = err_q;
  assign cls_in   = op_class(op_code);

  // Faults are judged against the stack as it stands at the accept edge.
  always_comb begin
    acc_err = ERR_NONE;
    case (cls_in)
      CL_ILL:   acc_err = ERR_ILLEGAL;
      CL_POP:   if (depth == '0) acc_err = ERR_UNDER;
      CL_DUP:   if (depth == '0) acc_err = ERR_UNDER;
                else if (depth == FULL) acc_err = ERR_OVER;
      CL_CONST: if (depth == FULL) acc_err = ERR_OVER;
      CL_BIN:   if (depth < DW'(2)) acc_err = ERR_UNDER;
      default:  acc_err = ERR_NONE;
    endcase
  end

  // A push spills the old TOS just below the new one; FETCH reads the entry
  // directly below TOS so it is ready for the ALU state.
  assign ram_we    = (state == S_PUSH) && (cls != CL_NOP) && (depth != '0);
  assign ram_waddr = AW'(depth - DW'(1));
  assign ram_re    = (state == S_FETCH);
  assign ram_raddr = AW'(depth - DW'(2));

  opstack_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (tos),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rdata)
  );

  // Binary ops take the entry below TOS as the left operand (isub = next - tos).
  always_comb begin
    nxt_s = signed'(rdata);
    tos_s = signed'(tos);
    case (op)
      OP_IADD: alu_res = nxt_s + tos_s;
      OP_ISUB: alu_res = nxt_s - tos_s;
      OP_IAND: alu_res = nxt_s & tos_s;
      OP_IOR:  alu_res = nxt_s | tos_s;
      OP_IXOR: alu_res = nxt_s ^ tos_s;
      default: alu_res = (depth >= DW'(2)) ? rdata : '0;
    endcase
  end

  // Op latch: captured on the accept edge, no reset needed.
  // iconst_m1..iconst_5 map to op_code-3; modular subtraction yields the
  // sign-extended result (02 -> all ones).
  always_ff @(posedge clk) begin
    if (accept) begin
      op       <= op_code;
      cls      <= cls_in;
      push_val <= WIDTH'(op_code) - WIDTH'(3);
    end
  end

  // Controller FSM and architectural stack state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tos   <= '0;
      depth <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      err_q <= ERR_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (acc_err != ERR_NONE) begin
              state <= S_HALT;
              err   <= 1'b1;
              err_q <= acc_err;
            end else if (cls_in == CL_POP || cls_in == CL_BIN) begin
              state <= S_FETCH;
            end else begin
              state <= S_PUSH;
            end
          end
        end
        S_PUSH: begin
          if (cls != CL_NOP) begin
            if (cls == CL_CONST) tos <= push_val;
            depth <= depth + DW'(1);
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_FETCH: state <= S_ALU;
        S_ALU: begin
          tos   <= alu_res;
          depth <= depth - DW'(1);
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opstack_ctrl.sv
// tb_opstack_ctrl -- self-checking bench for opstack_ctrl (DEPTH 16, WIDTH 32).
module tb_opstack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [7:0]  op_code;
  logic        op_ready;
  logic        done;
  logic [31:0] tos;
  logic [4:0]  depth;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  opstack_ctrl #(.DEPTH(16), .WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_ready (op_ready),
    .done     (done),
    .tos      (tos),
    .depth    (depth),
    .err      (err),
    .err_code (err_code)
  );

  typedef struct packed {
    logic [31:0] tos;
    logic [4:0]  depth;
    logic [7:0]  lat;
  } exp_t;

  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] tos;
    logic [4:0]  depth;
    logic [7:0]  lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!op_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Issue one op expected to retire; expectation queued at issue, popped on done.
  task automatic do_op(input logic [7:0] code, input logic [31:0] etos,
                       input logic [4:0] edep, input int elat, input bit hold);
    exp_t e;
    int   n;
    sb.push_back('{etos, edep, 8'(elat)});
    wait_ready();
    check("ready_before_op", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_code  = code;
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(e.lat));
    check("tos", tos, e.tos);
    check("depth", 32'(depth), 32'(e.depth));
    check("err_clear", 32'(err), 32'd0);
    check("ready_with_done", 32'(op_ready), 32'd1);
  endtask

  // Issue an op expected to fault: no done, halt with the given code, frozen stack.
  task automatic do_fault(input logic [7:0] code, input logic [1:0] ecode,
                          input logic [31:0] etos, input logic [4:0] edep);
    bit seen = 1'b0;
    wait_ready();
    op_valid = 1'b1;
    op_code  = code;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    // Ops offered while halted must be ignored.
    op_valid = 1'b1;
    op_code  = 8'h03;
    repeat (3) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    check("fault_no_done", 32'(seen), 32'd0);
    check("fault_err", 32'(err), 32'd1);
    check("fault_code", 32'(err_code), 32'(ecode));
    check("fault_ready_low", 32'(op_ready), 32'd0);
    check("fault_depth", 32'(depth), 32'(edep));
    check("fault_tos", tos, etos);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_tos", tos, 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("rst_ready", 32'(op_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] vals [16];
    logic [7:0]  c;
    logic [31:0] et;
    bit          seen;

    vecs[0]  = '{8'h02, 32'hFFFF_FFFF, 5'd1, 8'd1};
    vecs[1]  = '{8'h03, 32'h0000_0000, 5'd2, 8'd1};
    vecs[2]  = '{8'h04, 32'h0000_0001, 5'd3, 8'd1};
    vecs[3]  = '{8'h00, 32'h0000_0001, 5'd3, 8'd1};
    vecs[4]  = '{8'h60, 32'h0000_0001, 5'd2, 8'd2};
    vecs[5]  = '{8'h64, 32'hFFFF_FFFE, 5'd1, 8'd2};
    vecs[6]  = '{8'h59, 32'hFFFF_FFFE, 5'd2, 8'd1};
    vecs[7]  = '{8'h57, 32'hFFFF_FFFE, 5'd1, 8'd2};
    vecs[8]  = '{8'h05, 32'h0000_0002, 5'd2, 8'd1};
    vecs[9]  = '{8'h7E, 32'h0000_0002, 5'd1, 8'd2};
    vecs[10] = '{8'h08, 32'h0000_0005, 5'd2, 8'd1};
    vecs[11] = '{8'h80, 32'h0000_0007, 5'd1, 8'd2};
    vecs[12] = '{8'h06, 32'h0000_0003, 5'd2, 8'd1};
    vecs[13] = '{8'h82, 32'h0000_0004, 5'd1, 8'd2};
    vecs[14] = '{8'h57, 32'h0000_0000, 5'd0, 8'd2};
    vecs[15] = '{8'h00, 32'h0000_0000, 5'd0, 8'd1};

    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("init_tos", tos, 32'd0);
    check("init_depth", 32'(depth), 32'd0);
    check("init_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("init_ready", 32'(op_ready), 32'd1);
    check("init_err", 32'(err), 32'd0);
    check("init_err_code", 32'(err_code), 32'd0);

    // Main arithmetic / stack sequence from an empty stack.
    for (int i = 0; i < 16; i++)
      do_op(vecs[i].code, vecs[i].tos, vecs[i].depth, int'(vecs[i].lat), 1'b0);

    // Illegal opcode.
    do_fault(8'hFF, 2'b11, 32'd0, 5'd0);

    // Reset while an iadd is in FETCH.
    do_reset();
    do_op(8'h02, 32'hFFFF_FFFF, 5'd1, 1, 1'b0);
    do_op(8'h03, 32'h0000_0000, 5'd2, 1, 1'b0);
    op_valid = 1'b1;
    op_code  = 8'h60;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("midfetch_busy", 32'(op_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check("midfetch_depth", 32'(depth), 32'd0);
    check("midfetch_tos", tos, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midfetch_no_done", 32'(seen), 32'd0);
    check("midfetch_ready", 32'(op_ready), 32'd1);
    check("midfetch_depth_after", 32'(depth), 32'd0);

    // Underflow on iadd from an empty stack.
    do_reset();
    do_fault(8'h60, 2'b01, 32'd0, 5'd0);

    // Fill to capacity, then overflow.
    do_reset();
    for (int i = 0; i < 16; i++)
      do_op(8'h08, 32'd5, 5'(i + 1), 1, 1'b0);
    do_fault(8'h03, 2'b10, 32'd5, 5'd16);

    // Fill with distinct values, then pop everything back out.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      c = 8'(2 + (i % 7));
      vals[i] = 32'(c) - 32'd3;
      do_op(c, vals[i], 5'(i + 1), 1, 1'b0);
    end
    for (int d = 16; d >= 1; d--) begin
      et = (d >= 2) ? vals[d-2] : 32'd0;
      do_op(8'h57, et, 5'(d - 1), 2, 1'b0);
    end

    // Streaming with op_valid held high across the whole sequence.
    do_reset();
    do_op(8'h02, 32'hFFFF_FFFF, 5'd1, 1, 1'b1);
    do_op(8'h04, 32'h0000_0001, 5'd2, 1, 1'b1);
    do_op(8'h60, 32'h0000_0000, 5'd1, 2, 1'b1);
    do_op(8'h00, 32'h0000_0000, 5'd1, 1, 1'b1);
    op_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_idle_depth", 32'(depth), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/opstack_ctrl.md
OPSTACK_CTRL -- requirements
Module: opstack_ctrl

Interface
REQ-001 Param DEPTH, default 16, operand-stack entries (power of two, >=2).
REQ-002 Param WIDTH, default 32, stack word width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_valid  input  1  op_code valid.
REQ-006 op_code  input  8  JVM opcode.
REQ-007 op_ready  output  1  controller can accept; high exactly when state==IDLE.
REQ-008 done  output  1  one-cycle pulse, op retired.
REQ-009 tos  output  WIDTH  current top-of-stack value (0 when depth 0).
REQ-010 depth  output  $clog2(DEPTH)+1  entry count, 0..DEPTH.
REQ-011 err  output  1  sticky fault flag.
REQ-012 err_code  output  2  00 none, 01 underflow, 10 overflow, 11 illegal opcode.

Function
REQ-013 Op accepted on the edge where op_valid && op_ready; op_code latched then; op_valid while !op_ready is ignored.
REQ-014 Supported: 00 nop; 02..08 iconst_m1..iconst_5 (push -1..5, sign-extended); 57 pop; 59 dup; 60 iadd; 64 isub; 7E iand; 80 ior; 82 ixor; any other code is illegal.
REQ-015 TOS held in a register; entries below TOS in a sync-read RAM, entry i at address i (0 = bottom).
REQ-016 FSM states IDLE, PUSH, FETCH, ALU, HALT.
REQ-017 Checks at accept: pop with depth==0, dup with depth==0, binop with depth<2 -> underflow; iconst/dup with depth==DEPTH -> overflow; illegal code -> illegal; on any fault go HALT, no stack change, no done.
REQ-018 nop/iconst/dup: IDLE->PUSH->IDLE; in PUSH, if depth>0 write tos to RAM[depth-1], tos<=value (dup: unchanged tos), depth+1 (nop: no update).
REQ-019 pop/binop: IDLE->FETCH (RAM read addr depth-2 issued)->ALU->IDLE.
REQ-020 ALU for pop: tos<=RAM data if depth>=2 else 0; depth-1.
REQ-021 ALU for binop: tos<=next OP tos (isub = next - tos), depth-1; WIDTH-bit two's-complement wrap, no overflow flag.
REQ-022 done is registered, high for exactly the one cycle after the final update edge; latency accept-edge-to-done: nop/iconst/dup 1 cycle, pop/binop 2 cycles.
REQ-023 done and op_ready coincide; a new op may be accepted in the done cycle (back-to-back: one op per 2 clk for push-class, per 3 clk for pop/binop).
REQ-024 HALT: err=1, err_code held, op_ready=0, tos/depth frozen, until reset.

Reset
REQ-025 rst_n low asynchronously forces state IDLE, tos 0, depth 0, done 0, err 0, err_code 00; op_ready high after release.
REQ-026 Reset mid-op aborts the op with no done; RAM contents not reset and not relied on.

Structure
REQ-027 Shared package opstack_pkg holds opcode constants, FSM state enum, err_code enum, DEPTH/WIDTH defaults.
REQ-028 Sub-module opstack_ram: DEPTH x WIDTH, one write port, one sync-read port (1-cycle read latency).

Verification
REQ-029 Reset; ops 02,03,04,60 each on op_ready -> done after each; final tos=1, depth=2, err=0.
REQ-030 Continue with 64 -> tos=FFFFFFFE, depth=1; then 59 -> depth 2, tos FFFFFFFE; 57 -> depth 1.
REQ-031 From reset, op 60 -> err=1, err_code=01, no done, op_ready stays 0, depth 0.
REQ-032 16x op 08 then 03 -> depth=16, tos=5, err_code=10; 16x op 57 after fresh reset-and-fill -> depth 0, tos 0.
REQ-033 Op FF -> err_code=11; rst_n pulsed low mid-FETCH of an iadd -> no done, depth 0, tos 0, op_ready 1 after release.
REQ-034 op_valid held high streaming 02,04,60,00 -> each accepted on its done cycle, latencies 1,1,2,1 cycles, tos=0.
